// File: rtl/fir_pkg.sv
// Shared types and helpers for the multi-channel FIR tap delay line.
package fir_pkg;

    localparam int SAMPLE_DW = 16;

    typedef logic signed [SAMPLE_DW-1:0] sample_t;

    typedef enum logic [0:0] {S_IDLE, S_FLUSH} tapline_state_t;

    // Index width that stays at least 1 bit so single-channel builds still have a port.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fir_tap_bank.sv
// One channel's sample history: TAPS-deep shift register plus saturating fill count.
module fir_tap_bank #(
    parameter int DW   = 16,
    parameter int TAPS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 shift_en,
    input  logic                 clr,
    input  logic signed [DW-1:0] din,
    output logic signed [DW-1:0] taps [0:TAPS-1],
    output logic                 primed
);

    localparam int FW = $clog2(TAPS + 1);

    logic [FW-1:0] fill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill <= '0;
            for (int k = 0; k < TAPS; k++) taps[k] <= '0;
        end else if (clr) begin
            fill <= '0;
            for (int k = 0; k < TAPS; k++) taps[k] <= '0;
        end else if (shift_en) begin
            taps[0] <= din;
            for (int k = 1; k < TAPS; k++) taps[k] <= taps[k-1];
            if (fill != FW'(TAPS)) fill <= fill + FW'(1);
        end
    end

    // Looks ahead through this cycle's shift so the caller can register it with the new taps.
    assign primed = (fill == FW'(TAPS)) || (shift_en && fill == FW'(TAPS - 1));

endmodule

// File: rtl/fir_tap_line_mc.sv
// Multi-channel FIR tap line: handshake, flush sweep FSM, per-channel banks and output register.
module fir_tap_line_mc
    import fir_pkg::*;
#(
    parameter int  DW   = 16,
    parameter int  TAPS = 8,
    parameter int  CH   = 2,
    localparam int CW   = clog2_min1(CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    input  logic [CW-1:0]        in_ch,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CW-1:0]        out_ch,
    output logic signed [DW-1:0] out_taps [0:TAPS-1],
    output logic                 out_primed,
    output logic                 busy,
    output logic                 err_ch
);

    tapline_state_t state, state_next;
    logic [CW-1:0]  fcnt;
    logic           accept, ch_ok;
    logic [CH-1:0]  shift_en, clr, bank_primed;
    logic signed [DW-1:0] bank_taps [CH][0:TAPS-1];
    logic signed [DW-1:0] next_taps [0:TAPS-1];
    logic                 next_primed;

    assign in_ready = (state == S_IDLE) && !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign ch_ok    = {1'b0, in_ch} < (CW+1)'(CH);

    for (genvar g = 0; g < CH; g++) begin : g_bank
        assign shift_en[g] = accept && ch_ok && (in_ch == CW'(g));
        assign clr[g]      = (state == S_FLUSH) && (fcnt == CW'(g));

        fir_tap_bank #(.DW(DW), .TAPS(TAPS)) u_bank (
            .clk      (clk),
            .rst      (rst),
            .shift_en (shift_en[g]),
            .clr      (clr[g]),
            .din      (in_data),
            .taps     (bank_taps[g]),
            .primed   (bank_primed[g])
        );
    end

    // Post-shift view of the selected channel, captured into the output register.
    always_comb begin
        next_primed = 1'b0;
        for (int k = 0; k < TAPS; k++) next_taps[k] = '0;
        for (int c = 0; c < CH; c++) begin
            if (in_ch == CW'(c)) begin
                next_primed = bank_primed[c];
                for (int k = 1; k < TAPS; k++) next_taps[k] = bank_taps[c][k-1];
            end
        end
        next_taps[0] = in_data;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (flush) state_next = S_FLUSH;
            S_FLUSH: if (!flush && fcnt == CW'(CH - 1)) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            fcnt  <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == S_FLUSH);
            if (state == S_IDLE || flush) fcnt <= '0;
            else                          fcnt <= fcnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_primed <= 1'b0;
            err_ch     <= 1'b0;
            for (int k = 0; k < TAPS; k++) out_taps[k] <= '0;
        end else begin
            err_ch <= accept && !ch_ok;
            if (state == S_IDLE && flush) begin
                out_valid <= 1'b0;
            end else if (accept && ch_ok) begin
                out_valid  <= 1'b1;
                out_ch     <= in_ch;
                out_primed <= next_primed;
                out_taps   <= next_taps;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_tap_line_mc.sv
// Directed bench for fir_tap_line_mc: three builds (CH=2/TAPS=8, CH=3, CH=1/TAPS=2/DW=24).
module tb_fir_tap_line_mc;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Build A: DW=16 TAPS=8 CH=2
    logic              a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic              a_out_primed, a_busy, a_err_ch;
    logic signed [15:0] a_in_data;
    logic [0:0]        a_in_ch, a_out_ch;
    logic signed [15:0] a_taps [0:7];

    fir_tap_line_mc #(.DW(16), .TAPS(8), .CH(2)) dut_a (
        .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_ch(a_in_ch), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_ch(a_out_ch), .out_taps(a_taps), .out_primed(a_out_primed), .busy(a_busy),
        .err_ch(a_err_ch)
    );

    // Build B: DW=16 TAPS=8 CH=3
    logic              b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic              b_out_primed, b_busy, b_err_ch;
    logic signed [15:0] b_in_data;
    logic [1:0]        b_in_ch, b_out_ch;
    logic signed [15:0] b_taps [0:7];

    fir_tap_line_mc #(.DW(16), .TAPS(8), .CH(3)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_ch(b_in_ch), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_ch(b_out_ch), .out_taps(b_taps), .out_primed(b_out_primed), .busy(b_busy),
        .err_ch(b_err_ch)
    );

    // Build C: DW=24 TAPS=2 CH=1
    logic              c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic              c_out_primed, c_busy, c_err_ch;
    logic signed [23:0] c_in_data;
    logic [0:0]        c_in_ch, c_out_ch;
    logic signed [23:0] c_taps [0:1];

    fir_tap_line_mc #(.DW(24), .TAPS(2), .CH(1)) dut_c (
        .clk(clk), .rst(rst), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .in_ch(c_in_ch), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_ch(c_out_ch), .out_taps(c_taps), .out_primed(c_out_primed), .busy(c_busy),
        .err_ch(c_err_ch)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a_flush = 0; a_in_valid = 0; a_in_data = '0; a_in_ch = '0; a_out_ready = 1;
        b_flush = 0; b_in_valid = 0; b_in_data = '0; b_in_ch = '0; b_out_ready = 1;
        c_flush = 0; c_in_valid = 0; c_in_data = '0; c_in_ch = '0; c_out_ready = 1;
        tick(); tick();

        // 1. reset values, then async reset mid-stream
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out_ch", 32'(a_out_ch), 32'd0);
        chk("rst_taps0", 32'(a_taps[0]), 32'd0);
        chk("rst_primed", 32'(a_out_primed), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_err", 32'(a_err_ch), 32'd0);
        rst = 1'b0;
        #1 chk("rst_in_ready", 32'(a_in_ready), 32'd1);
        a_in_valid = 1; a_in_ch = 0; a_in_data = 16'h55;
        tick();
        chk("pre_rst_valid", 32'(a_out_valid), 32'd1);
        chk("pre_rst_taps0", 32'(a_taps[0]), 32'h55);
        a_in_data = 16'h56;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(a_out_valid), 32'd0);
        chk("async_rst_taps0", 32'(a_taps[0]), 32'd0);
        tick(); tick(); tick();
        rst = 1'b0;
        a_in_valid = 0;
        #1;
        chk("post_rst_in_ready", 32'(a_in_ready), 32'd1);
        chk("post_rst_valid", 32'(a_out_valid), 32'd0);

        // 2. single channel fill on ch0
        for (int i = 1; i <= 9; i++) begin
            a_in_valid = 1; a_in_ch = 0; a_in_data = 16'(i);
            tick();
            chk("fill_valid", 32'(a_out_valid), 32'd1);
            if (i == 3) begin
                chk("fill3_t0", 32'(a_taps[0]), 32'd3);
                chk("fill3_t1", 32'(a_taps[1]), 32'd2);
                chk("fill3_t2", 32'(a_taps[2]), 32'd1);
                chk("fill3_t3", 32'(a_taps[3]), 32'd0);
                chk("fill3_t7", 32'(a_taps[7]), 32'd0);
                chk("fill3_primed", 32'(a_out_primed), 32'd0);
            end
            if (i == 7) chk("fill7_primed", 32'(a_out_primed), 32'd0);
            if (i == 8) chk("fill8_primed", 32'(a_out_primed), 32'd1);
            if (i == 9) begin
                for (int k = 0; k < 8; k++) chk("fill9_tap", 32'(a_taps[k]), 32'(9 - k));
                chk("fill9_primed", 32'(a_out_primed), 32'd1);
            end
        end

        // 3. interleaved channels
        a_in_ch = 0; a_in_data = 16'h0A;
        tick();
        a_in_ch = 1; a_in_data = 16'h0B;
        tick();
        chk("il_ch1", 32'(a_out_ch), 32'd1);
        chk("il_ch1_t0", 32'(a_taps[0]), 32'h0B);
        chk("il_ch1_t1", 32'(a_taps[1]), 32'd0);
        chk("il_ch1_primed", 32'(a_out_primed), 32'd0);
        a_in_ch = 0; a_in_data = 16'h0C;
        tick();
        chk("il_ch0", 32'(a_out_ch), 32'd0);
        chk("il_ch0_t0", 32'(a_taps[0]), 32'h0C);
        chk("il_ch0_t1", 32'(a_taps[1]), 32'h0A);
        chk("il_ch0_t2", 32'(a_taps[2]), 32'd9);

        // 4. backpressure
        a_out_ready = 0; a_in_ch = 1; a_in_data = 16'h11;
        #1 chk("bp_in_ready", 32'(a_in_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_valid", 32'(a_out_valid), 32'd1);
            chk("bp_ch", 32'(a_out_ch), 32'd0);
            chk("bp_t0", 32'(a_taps[0]), 32'h0C);
            chk("bp_in_ready_hold", 32'(a_in_ready), 32'd0);
        end
        a_out_ready = 1;
        #1 chk("bp_release_ready", 32'(a_in_ready), 32'd1);
        tick();
        a_in_valid = 0;
        chk("bp_rel_ch", 32'(a_out_ch), 32'd1);
        chk("bp_rel_t0", 32'(a_taps[0]), 32'h11);
        chk("bp_rel_t1", 32'(a_taps[1]), 32'h0B);
        tick();
        chk("bp_drain_valid", 32'(a_out_valid), 32'd0);

        // 5. flush with pending output and concurrent sample
        a_in_valid = 1; a_in_ch = 0; a_in_data = 16'h20;
        tick();
        chk("fl_pre_valid", 32'(a_out_valid), 32'd1);
        a_in_ch = 1; a_in_data = 16'h21; a_flush = 1;
        #1 chk("fl_in_ready", 32'(a_in_ready), 32'd0);
        tick();
        a_flush = 0; a_in_ch = 1; a_in_data = 16'h5;
        chk("fl_valid_drop", 32'(a_out_valid), 32'd0);
        chk("fl_busy1", 32'(a_busy), 32'd1);
        tick();
        chk("fl_busy2", 32'(a_busy), 32'd1);
        chk("fl_in_ready2", 32'(a_in_ready), 32'd0);
        chk("fl_valid2", 32'(a_out_valid), 32'd0);
        tick();
        chk("fl_busy_end", 32'(a_busy), 32'd0);
        chk("fl_ready_end", 32'(a_in_ready), 32'd1);
        tick();
        chk("fl_new_valid", 32'(a_out_valid), 32'd1);
        chk("fl_new_ch", 32'(a_out_ch), 32'd1);
        chk("fl_new_t0", 32'(a_taps[0]), 32'd5);
        chk("fl_new_t1", 32'(a_taps[1]), 32'd0);
        chk("fl_new_primed", 32'(a_out_primed), 32'd0);
        a_in_ch = 0; a_in_data = 16'h7;
        tick();
        a_in_valid = 0;
        chk("fl_ch0_t0", 32'(a_taps[0]), 32'd7);
        chk("fl_ch0_t1", 32'(a_taps[1]), 32'd0);
        tick();

        // 6. bad channel on the CH=3 build
        b_in_valid = 1; b_in_ch = 2; b_in_data = 16'h33;
        tick();
        b_in_ch = 0; b_in_data = 16'h44;
        tick();
        chk("bad_pre_err", 32'(b_err_ch), 32'd0);
        b_in_ch = 3; b_in_data = 16'h99;
        tick();
        b_in_valid = 0;
        chk("bad_err", 32'(b_err_ch), 32'd1);
        chk("bad_valid", 32'(b_out_valid), 32'd0);
        tick();
        chk("bad_err_pulse", 32'(b_err_ch), 32'd0);
        b_in_valid = 1; b_in_ch = 2; b_in_data = 16'h55;
        tick();
        chk("bad_ch2_t0", 32'(b_taps[0]), 32'h55);
        chk("bad_ch2_t1", 32'(b_taps[1]), 32'h33);
        chk("bad_ch2_t2", 32'(b_taps[2]), 32'd0);
        b_in_ch = 0; b_in_data = 16'h66;
        tick();
        chk("bad_ch0_t0", 32'(b_taps[0]), 32'h66);
        chk("bad_ch0_t1", 32'(b_taps[1]), 32'h44);
        chk("bad_ch0_t2", 32'(b_taps[2]), 32'd0);
        b_in_ch = 1; b_in_data = 16'h77;
        tick();
        b_in_valid = 0;
        chk("bad_ch1_ch", 32'(b_out_ch), 32'd1);
        chk("bad_ch1_t1", 32'(b_taps[1]), 32'd0);
        tick();

        // 7. corner build CH=1 TAPS=2 DW=24: fill then flush
        for (int i = 1; i <= 3; i++) begin
            c_in_valid = 1; c_in_ch = 0; c_in_data = 24'(i);
            tick();
            chk("c_fill_t0", 32'(c_taps[0]), 32'(i));
            chk("c_fill_t1", 32'(c_taps[1]), 32'(i - 1));
            chk("c_fill_primed", 32'(c_out_primed), (i >= 2) ? 32'd1 : 32'd0);
        end
        c_in_data = 24'h50; c_flush = 1;
        #1 chk("c_fl_in_ready", 32'(c_in_ready), 32'd0);
        tick();
        c_flush = 0; c_in_data = 24'h123456;
        chk("c_fl_busy", 32'(c_busy), 32'd1);
        chk("c_fl_valid", 32'(c_out_valid), 32'd0);
        tick();
        chk("c_fl_busy_end", 32'(c_busy), 32'd0);
        chk("c_fl_ready", 32'(c_in_ready), 32'd1);
        tick();
        chk("c_new_valid", 32'(c_out_valid), 32'd1);
        chk("c_new_t0", 32'(c_taps[0]), 32'h123456);
        chk("c_new_t1", 32'(c_taps[1]), 32'd0);
        chk("c_new_primed", 32'(c_out_primed), 32'd0);
        c_in_data = 24'h10;
        tick();
        c_in_valid = 0;
        chk("c_2nd_t1", 32'(c_taps[1]), 32'h123456);
        chk("c_2nd_primed", 32'(c_out_primed), 32'd1);
        chk("c_err", 32'(c_err_ch), 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
